// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, memory-stage controller state, and
// small helpers used by the memory access controller.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int PERF_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [PERF_W-1:0] perf_t;

    // Memory-stage controller states; HALTED is only left through reset.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        HALTED = 2'b11
    } memstate_t;

    // Clear the byte offset so the cache always sees a word-aligned address.
    function automatic word_t word_align(input word_t a);
        return a & ~word_t'(3);
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: accepts one load/store from the EX/MEM
// register, holds the data cache request until dhit, presents the captured
// load word for one DONE cycle, and parks in HALTED after a halt instruction.
module mem_access_ctrl
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  xmem_valid,
    input  logic  xmem_memread,
    input  logic  xmem_memwrite,
    input  logic  xmem_halt,
    input  word_t xmem_addr,
    input  word_t xmem_store,
    input  logic  flush,
    input  logic  dhit,
    input  word_t dmemload,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_busy,
    output word_t load_data,
    output logic  load_valid,
    output logic  halt_out,
    output perf_t access_cycles
);

    memstate_t state, next_state;

    word_t addr_q;
    word_t store_q;
    logic  is_store_q;
    word_t load_data_q;
    perf_t acc_cnt_q;

    logic  mem_op;
    logic  accept;
    logic  halt_go;

    // Saturating increment: the perf counter sticks at all-ones instead of wrapping.
    function automatic perf_t sat_inc(input perf_t v);
        return (v == '1) ? v : v + perf_t'(1);
    endfunction

    assign mem_op  = xmem_memread | xmem_memwrite;
    assign accept  = (state == IDLE) && xmem_valid && mem_op && !flush;
    // A memory op in the same instruction wins over halt.
    assign halt_go = (state == IDLE) && xmem_valid && xmem_halt && !mem_op && !flush;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; flush only matters while deciding to accept in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = ACCESS;
                end else if (halt_go) begin
                    next_state = HALTED;
                end
            end
            ACCESS: begin
                if (dhit) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from state plus the IDLE acceptance term for mem_busy.
    always_comb begin
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        mem_busy   = 1'b0;
        load_valid = 1'b0;
        halt_out   = 1'b0;
        case (state)
            IDLE: begin
                mem_busy = accept;
            end
            ACCESS: begin
                mem_busy = 1'b1;
                dmemREN  = !is_store_q;
                dmemWEN  = is_store_q;
            end
            DONE: begin
                load_valid = !is_store_q;
            end
            HALTED: begin
                halt_out = 1'b1;
            end
            default: begin
                mem_busy = 1'b0;
            end
        endcase
    end

    assign dmemaddr      = addr_q;
    assign dmemstore     = store_q;
    assign load_data     = load_data_q;
    assign access_cycles = acc_cnt_q;

    // Latch the request on acceptance; read+write together is treated as a store.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q     <= '0;
            store_q    <= '0;
            is_store_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= word_align(xmem_addr);
            store_q    <= xmem_store;
            is_store_q <= xmem_memwrite;
        end
    end

    // Capture the cache read word on the completing edge of a load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            load_data_q <= '0;
        end else if ((state == ACCESS) && dhit && !is_store_q) begin
            load_data_q <= dmemload;
        end
    end

    // Count every cycle spent in ACCESS, saturating at the top.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_cnt_q <= '0;
        end else if (state == ACCESS) begin
            acc_cnt_q <= sat_inc(acc_cnt_q);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: scoreboard of expected load words, per-feature
// scenario tasks run in sequence from one initial block.
module tb_mem_access_ctrl;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  xmem_valid, xmem_memread, xmem_memwrite, xmem_halt;
    word_t xmem_addr, xmem_store;
    logic  flush, dhit;
    word_t dmemload;
    logic  dmemREN, dmemWEN;
    word_t dmemaddr, dmemstore;
    logic  mem_busy;
    word_t load_data;
    logic  load_valid;
    logic  halt_out;
    perf_t access_cycles;

    int    vec_cnt = 0;
    int    err_cnt = 0;
    word_t exp_q[$];
    int    exp_acc = 0;
    word_t last_load = '0;

    mem_access_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .xmem_valid(xmem_valid), .xmem_memread(xmem_memread),
        .xmem_memwrite(xmem_memwrite), .xmem_halt(xmem_halt),
        .xmem_addr(xmem_addr), .xmem_store(xmem_store),
        .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_busy(mem_busy), .load_data(load_data), .load_valid(load_valid),
        .halt_out(halt_out), .access_cycles(access_cycles)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        xmem_valid = 0; xmem_memread = 0; xmem_memwrite = 0; xmem_halt = 0;
        xmem_addr = '0; xmem_store = '0; flush = 0; dhit = 0; dmemload = '0;
    endtask

    task automatic do_reset();
        #2 nRST = 0;
        #3 nRST = 1;
        exp_acc = 0;
        last_load = '0;
        tick();
    endtask

    // Drives one accepted transaction with dhit on ACCESS cycle hit_at and
    // tallies what the DUT presented on every cycle through DONE and back to IDLE.
    task automatic do_xact(input logic rd, input logic wr, input word_t addr,
                           input word_t sdata, input word_t ldata, input int hit_at,
                           input logic flush_acc,
                           output int ren_n, output int wen_n, output int busy_n,
                           output int lv_n, output int lv_at, output int both_n,
                           output word_t addr_seen, output word_t store_seen,
                           output word_t ld_seen, output logic unstable);
        ren_n = 0; wen_n = 0; busy_n = 0; lv_n = 0; lv_at = -1; both_n = 0;
        addr_seen = '0; store_seen = '0; ld_seen = '0; unstable = 0;
        xmem_valid = 1; xmem_memread = rd; xmem_memwrite = wr;
        xmem_addr = addr; xmem_store = sdata; flush = 0; dhit = 0;
        #1;
        busy_n += int'(mem_busy);
        ren_n  += int'(dmemREN);
        wen_n  += int'(dmemWEN);
        for (int k = 1; k <= hit_at + 2; k++) begin
            @(posedge CLK);
            #1;
            xmem_valid = 0; xmem_memread = 0; xmem_memwrite = 0;
            xmem_addr = $urandom; xmem_store = $urandom;
            flush = flush_acc && (k <= hit_at + 1);
            dhit = (k == hit_at);
            dmemload = (k == hit_at) ? ldata : word_t'($urandom);
            #1;
            busy_n += int'(mem_busy);
            ren_n  += int'(dmemREN);
            wen_n  += int'(dmemWEN);
            if (dmemREN && dmemWEN) both_n++;
            if (k == 1) begin
                addr_seen = dmemaddr;
                store_seen = dmemstore;
            end else if (k <= hit_at && (dmemaddr !== addr_seen || dmemstore !== store_seen)) begin
                unstable = 1;
            end
            if (load_valid) begin
                lv_n++;
                lv_at = k;
                ld_seen = load_data;
            end
        end
        idle_inputs();
        exp_acc = (exp_acc + hit_at > 65535) ? 65535 : exp_acc + hit_at;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        #3;
        vec_cnt++;
        if ({dmemREN, dmemWEN, mem_busy, load_valid, halt_out} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b want 00000", {dmemREN, dmemWEN, mem_busy, load_valid, halt_out});
        end
        vec_cnt++;
        if (dmemaddr !== '0 || dmemstore !== '0 || load_data !== '0 || access_cycles !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", dmemaddr, dmemstore, load_data, access_cycles);
        end
        #4 nRST = 1;
        tick();
        exp_acc = 0;
    endtask

    task automatic test_load();
        int ren_n, wen_n, busy_n, lv_n, lv_at, both_n;
        word_t a_s, s_s, ld_s, exp_w;
        logic unst;
        exp_q.push_back(32'hDEAD_BEEF);
        do_xact(1, 0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3, 0,
                ren_n, wen_n, busy_n, lv_n, lv_at, both_n, a_s, s_s, ld_s, unst);
        exp_w = exp_q.pop_front();
        last_load = exp_w;
        vec_cnt++;
        if (ren_n != 3 || wen_n != 0) begin
            err_cnt++; $display("FAIL load_req: got ren=%0d wen=%0d want 3 0", ren_n, wen_n);
        end
        vec_cnt++;
        if (busy_n != 4) begin
            err_cnt++; $display("FAIL load_busy: got %0d want 4", busy_n);
        end
        vec_cnt++;
        if (lv_n != 1 || ld_s !== exp_w) begin
            err_cnt++; $display("FAIL load_data: got lv=%0d data=%h want 1 %h", lv_n, ld_s, exp_w);
        end
        vec_cnt++;
        if (a_s !== 32'h0000_0104 || unst) begin
            err_cnt++; $display("FAIL load_addr: got %h unstable=%0b want 00000104 0", a_s, unst);
        end
        vec_cnt++;
        if (access_cycles !== 16'd3 || load_data !== 32'hDEAD_BEEF) begin
            err_cnt++; $display("FAIL load_cnt: got %0d %h want 3 deadbeef", access_cycles, load_data);
        end
    endtask

    task automatic test_store();
        int ren_n, wen_n, busy_n, lv_n, lv_at, both_n;
        word_t a_s, s_s, ld_s;
        logic unst;
        do_xact(0, 1, 32'h0000_0203, 32'h1234_5678, 32'hFFFF_FFFF, 1, 0,
                ren_n, wen_n, busy_n, lv_n, lv_at, both_n, a_s, s_s, ld_s, unst);
        vec_cnt++;
        if (wen_n != 1 || ren_n != 0 || lv_n != 0) begin
            err_cnt++; $display("FAIL store_req: got wen=%0d ren=%0d lv=%0d want 1 0 0", wen_n, ren_n, lv_n);
        end
        vec_cnt++;
        if (a_s !== 32'h0000_0200 || s_s !== 32'h1234_5678) begin
            err_cnt++; $display("FAIL store_bus: got %h %h want 00000200 12345678", a_s, s_s);
        end
        vec_cnt++;
        if (load_data !== last_load || access_cycles !== perf_t'(exp_acc)) begin
            err_cnt++; $display("FAIL store_hold: got %h %0d want %h %0d", load_data, access_cycles, last_load, exp_acc);
        end
        do_xact(1, 1, 32'h0000_0ABF, 32'hCAFE_0001, 32'h0, 2, 0,
                ren_n, wen_n, busy_n, lv_n, lv_at, both_n, a_s, s_s, ld_s, unst);
        vec_cnt++;
        if (wen_n != 2 || ren_n != 0 || lv_n != 0 || a_s !== 32'h0000_0ABC || s_s !== 32'hCAFE_0001) begin
            err_cnt++; $display("FAIL rdwr_store: got wen=%0d ren=%0d lv=%0d %h %h want 2 0 0 00000abc cafe0001",
                                wen_n, ren_n, lv_n, a_s, s_s);
        end
    endtask

    task automatic test_flush();
        int ren_n, wen_n, busy_n, lv_n, lv_at, both_n;
        word_t a_s, s_s, ld_s, exp_w;
        logic unst;
        exp_q.push_back(32'h0BAD_F00D);
        do_xact(1, 0, 32'h0000_1000, 32'h0, 32'h0BAD_F00D, 3, 1,
                ren_n, wen_n, busy_n, lv_n, lv_at, both_n, a_s, s_s, ld_s, unst);
        exp_w = exp_q.pop_front();
        last_load = exp_w;
        vec_cnt++;
        if (ren_n != 3 || lv_n != 1 || lv_at != 4 || ld_s !== exp_w) begin
            err_cnt++; $display("FAIL flush_access: got ren=%0d lv=%0d at=%0d %h want 3 1 4 %h",
                                ren_n, lv_n, lv_at, ld_s, exp_w);
        end
        xmem_valid = 1; xmem_memread = 1; xmem_addr = 32'h0000_2000; flush = 1;
        #1;
        vec_cnt++;
        if (mem_busy !== 1'b0) begin
            err_cnt++; $display("FAIL flush_idle_busy: got %b want 0", mem_busy);
        end
        tick();
        tick();
        vec_cnt++;
        if (dmemREN !== 1'b0 || mem_busy !== 1'b0) begin
            err_cnt++; $display("FAIL flush_idle_req: got ren=%b busy=%b want 0 0", dmemREN, mem_busy);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int ren_n, wen_n, busy_n, lv_n, lv_at, both_n, hit, kind;
        word_t a_s, s_s, ld_s, addr, sd, ld, exp_w;
        logic unst, rd, wr, fl, is_ld;
        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 2);
            rd = (kind != 1);
            wr = (kind != 0);
            is_ld = rd && !wr;
            hit = $urandom_range(1, 4);
            fl = 1'($urandom_range(0, 1));
            addr = $urandom; sd = $urandom; ld = $urandom;
            if (is_ld) exp_q.push_back(ld);
            do_xact(rd, wr, addr, sd, ld, hit, fl,
                    ren_n, wen_n, busy_n, lv_n, lv_at, both_n, a_s, s_s, ld_s, unst);
            vec_cnt++;
            if (ren_n != (is_ld ? hit : 0) || wen_n != (is_ld ? 0 : hit) || both_n != 0 || busy_n != hit + 1) begin
                err_cnt++; $display("FAIL b2b_req[%0d]: got ren=%0d wen=%0d both=%0d busy=%0d want hit=%0d load=%0b",
                                    i, ren_n, wen_n, both_n, busy_n, hit, is_ld);
            end
            vec_cnt++;
            if (a_s !== (addr & 32'hFFFF_FFFC) || s_s !== sd || unst) begin
                err_cnt++; $display("FAIL b2b_bus[%0d]: got %h %h unst=%0b want %h %h 0",
                                    i, a_s, s_s, unst, addr & 32'hFFFF_FFFC, sd);
            end
            if (is_ld) begin
                exp_w = exp_q.pop_front();
                last_load = exp_w;
                vec_cnt++;
                if (lv_n != 1 || lv_at != hit + 1 || ld_s !== exp_w) begin
                    err_cnt++; $display("FAIL b2b_load[%0d]: got lv=%0d at=%0d %h want 1 %0d %h",
                                        i, lv_n, lv_at, ld_s, hit + 1, exp_w);
                end
            end else begin
                vec_cnt++;
                if (lv_n != 0 || load_data !== last_load) begin
                    err_cnt++; $display("FAIL b2b_store[%0d]: got lv=%0d hold=%h want 0 %h", i, lv_n, load_data, last_load);
                end
            end
        end
        vec_cnt++;
        if (access_cycles !== perf_t'(exp_acc) || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL b2b_cnt: got %0d q=%0d want %0d 0", access_cycles, exp_q.size(), exp_acc);
        end
    endtask

    task automatic test_halt();
        int ren_n, wen_n, busy_n, lv_n, lv_at, both_n;
        word_t a_s, s_s, ld_s, exp_w;
        logic unst;
        exp_q.push_back(32'h5555_AAAA);
        xmem_halt = 1;
        do_xact(1, 0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 1, 0,
                ren_n, wen_n, busy_n, lv_n, lv_at, both_n, a_s, s_s, ld_s, unst);
        exp_w = exp_q.pop_front();
        last_load = exp_w;
        vec_cnt++;
        if (ren_n != 1 || lv_at != 2 || ld_s !== exp_w || halt_out !== 1'b0) begin
            err_cnt++; $display("FAIL halt_priority: got ren=%0d at=%0d %h halt=%b want 1 2 %h 0",
                                ren_n, lv_at, ld_s, halt_out, exp_w);
        end
        xmem_valid = 1; xmem_halt = 1;
        #1;
        vec_cnt++;
        if (mem_busy !== 1'b0 || halt_out !== 1'b0) begin
            err_cnt++; $display("FAIL halt_pre: got busy=%b halt=%b want 0 0", mem_busy, halt_out);
        end
        tick();
        idle_inputs();
        #1;
        vec_cnt++;
        if (halt_out !== 1'b1) begin
            err_cnt++; $display("FAIL halt_set: got %b want 1", halt_out);
        end
        xmem_valid = 1; xmem_memread = 1; xmem_addr = 32'h0000_0300;
        tick();
        tick();
        vec_cnt++;
        if (dmemREN !== 1'b0 || mem_busy !== 1'b0 || halt_out !== 1'b1) begin
            err_cnt++; $display("FAIL halt_absorb: got ren=%b busy=%b halt=%b want 0 0 1", dmemREN, mem_busy, halt_out);
        end
        idle_inputs();
        #2 nRST = 0;
        #1;
        vec_cnt++;
        if (halt_out !== 1'b0 || load_data !== '0) begin
            err_cnt++; $display("FAIL halt_reset: got halt=%b ld=%h want 0 0", halt_out, load_data);
        end
        #2 nRST = 1;
        exp_acc = 0;
        last_load = '0;
        tick();
    endtask

    task automatic test_saturate_reset();
        do_reset();
        xmem_valid = 1; xmem_memread = 1; xmem_addr = 32'h0000_0500;
        tick();
        idle_inputs();
        repeat (100) tick();
        vec_cnt++;
        if (access_cycles !== 16'd100 || dmemREN !== 1'b1) begin
            err_cnt++; $display("FAIL cnt_100: got %0d ren=%b want 100 1", access_cycles, dmemREN);
        end
        repeat (70000) tick();
        vec_cnt++;
        if (access_cycles !== 16'hFFFF || dmemREN !== 1'b1 || mem_busy !== 1'b1) begin
            err_cnt++; $display("FAIL cnt_sat: got %h ren=%b busy=%b want ffff 1 1", access_cycles, dmemREN, mem_busy);
        end
        #2 nRST = 0;
        #1;
        vec_cnt++;
        if (dmemREN !== 1'b0 || mem_busy !== 1'b0 || access_cycles !== '0 || dmemaddr !== '0) begin
            err_cnt++; $display("FAIL reset_mid: got ren=%b busy=%b cnt=%h addr=%h want 0 0 0 0",
                                dmemREN, mem_busy, access_cycles, dmemaddr);
        end
        #2 nRST = 1;
        exp_acc = 0;
        tick();
        tick();
        vec_cnt++;
        if (dmemREN !== 1'b0 || access_cycles !== '0) begin
            err_cnt++; $display("FAIL reset_after: got ren=%b cnt=%h want 0 0", dmemREN, access_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_flush();
        test_back_to_back();
        test_halt();
        test_saturate_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
